// File: rtl/uart_pkg.sv
// Constants and types shared by the UART receive and transmit paths.
package uart_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;

  localparam int DEFAULT_DIV = 651;
  localparam int FIFO_AW     = 4;
  localparam int FIFO_DEPTH  = 1 << FIFO_AW;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; head entry is always on rd_data, zero when empty.
module sync_fifo #(
  parameter int AW = 4,
  parameter int W  = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid,
  output logic          full,
  output logic [AW:0]   count
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push, pop;

  always_comb begin
    full     = (cnt_q == (AW+1)'(DEPTH));
    rd_valid = (cnt_q != '0);
    pop      = rd_en && rd_valid;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    push     = wr_en && (!full || pop);
    wptr_d   = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d   = pop  ? rptr_q + 1'b1 : rptr_q;
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    rd_data  = rd_valid ? mem_q[rptr_q] : '0;
    count    = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a show-ahead byte FIFO,
// with sticky overrun / framing-error flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DIV = DEFAULT_DIV,
  parameter int AW  = FIFO_AW
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        rx,
  input  logic        rd_en,
  input  logic        clr_err,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic [AW:0] count,
  output logic        overrun,
  output logic        frame_err
);
  uart_state_e state_q, state_d;
  logic        sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [15:0] div_q, div_d;
  logic [3:0]  scnt_q, scnt_d;
  logic [2:0]  bidx_q, bidx_d;
  logic [7:0]  shift_q, shift_d;
  logic        overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic        rx_s, tick, push, ferr_set, ovr_set, pop, full;

  always_comb begin
    sync1_d  = rx;
    sync2_d  = sync1_q;
    rx_s     = sync2_q;
    prev_d   = rx_s;
    tick     = (div_q == 16'(DIV - 1));
    div_d    = tick ? 16'd0 : div_q + 16'd1;
    state_d  = state_q;
    scnt_d   = (tick && state_q != ST_IDLE) ? scnt_q + 4'd1 : scnt_q;
    bidx_d   = bidx_q;
    shift_d  = shift_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      ST_IDLE: if (prev_q && !rx_s) begin
        // restart the divider so sampling is phase-aligned to the start edge
        state_d = ST_START;
        scnt_d  = '0;
        div_d   = '0;
      end
      ST_START: if (tick && scnt_q == 4'd7) begin
        if (!rx_s) begin
          state_d = ST_DATA;
          scnt_d  = '0;
          bidx_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: if (tick && scnt_q == 4'd15) begin
        shift_d[bidx_q] = rx_s;
        bidx_d          = bidx_q + 3'd1;
        if (bidx_q == 3'd7) begin
          state_d = ST_STOP;
          scnt_d  = '0;
        end
      end
      ST_STOP: if (tick && scnt_q == 4'd15) begin
        state_d  = ST_IDLE;
        push     = rx_s;
        ferr_set = !rx_s;
      end
      default: state_d = ST_IDLE;
    endcase
    pop         = rd_en && rd_valid;
    ovr_set     = push && full && !pop;
    overrun_d   = ovr_set  || (overrun_q   && !clr_err);
    frame_err_d = ferr_set || (frame_err_q && !clr_err);
    overrun     = overrun_q;
    frame_err   = frame_err_q;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      div_q       <= '0;
      scnt_q      <= '0;
      bidx_q      <= '0;
      shift_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      div_q       <= div_d;
      scnt_q      <= scnt_d;
      bidx_q      <= bidx_d;
      shift_q     <= shift_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  sync_fifo #(.AW(AW), .W(8)) u_fifo (
    .clk      (sysclk),
    .reset    (reset),
    .wr_en    (push),
    .wr_data  (shift_q),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .full     (full),
    .count    (count)
  );
endmodule
